// File: rtl/spi_ram_cmd_arbiter.sv
// Round-robin arbiter for the single SPI RAM command port; address+data word pairs stay atomic.
// Define LOCK_TIMEOUT_EN to force-release a lock after TIMEOUT_CYCLES idle cycles in LOCKED.
module spi_ram_cmd_arbiter #(
  parameter int CMD_WIDTH      = 10,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [CMD_WIDTH-1:0]  req0_din,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [CMD_WIDTH-1:0]  req1_din,
  output logic                  req1_ready,
  output logic                  ram_rx_valid,
  output logic [CMD_WIDTH-1:0]  ram_din,
  input  logic                  ram_tx_valid,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rd_err,
  output logic                  lock_timeout,
  output logic                  owner,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, LOCKED, RD_ISSUE, RD_CAPT} state_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic                   ram_rx_valid_q, ram_rx_valid_d;
  logic [CMD_WIDTH-1:0]   ram_din_q, ram_din_d;
  logic                   rsp0_valid_q, rsp0_valid_d;
  logic                   rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   rd_err_q, rd_err_d;
  logic                   acc0, acc1;
  logic [CMD_WIDTH-1:0]   acc_word;

`ifdef LOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          lock_timeout_q, lock_timeout_d;
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    ram_rx_valid_d = 1'b0;
    ram_din_d      = ram_din_q;
    rsp0_valid_d   = 1'b0;
    rsp1_valid_d   = 1'b0;
    rsp_data_d     = rsp_data_q;
    rd_err_d       = 1'b0;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
`ifdef LOCK_TIMEOUT_EN
    tmo_cnt_d      = '0;
    lock_timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (req0_valid && (!req1_valid || last_grant_q)) req0_ready = 1'b1;
        else if (req1_valid)                              req1_ready = 1'b1;
      end
      LOCKED: begin
        req0_ready = !owner_q;
        req1_ready = owner_q;
      end
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT: begin
        state_d = IDLE;
        if (ram_tx_valid) begin
          rsp_data_d   = ram_dout;
          rsp0_valid_d = !owner_q;
          rsp1_valid_d = owner_q;
        end else begin
          rd_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end

    acc0     = req0_valid && req0_ready;
    acc1     = req1_valid && req1_ready;
    acc_word = acc1 ? req1_din : req0_din;

    if (acc0 || acc1) begin
      ram_rx_valid_d = 1'b1;
      ram_din_d      = acc_word;
      owner_d        = acc1;
      last_grant_d   = acc1;
      if (!acc_word[8])     state_d = LOCKED;
      else if (acc_word[9]) state_d = RD_ISSUE;
      else                  state_d = IDLE;
    end
`ifdef LOCK_TIMEOUT_EN
    else if (state_q == LOCKED) begin
      // last_grant keeps the stalled owner, so the other side wins the next contest.
      if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d        = IDLE;
        lock_timeout_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= 1'b1;
      last_grant_q   <= 1'b1;
      ram_rx_valid_q <= 1'b0;
      ram_din_q      <= '0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      rsp_data_q     <= '0;
      rd_err_q       <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      lock_timeout_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      ram_din_q      <= ram_din_d;
      rsp0_valid_q   <= rsp0_valid_d;
      rsp1_valid_q   <= rsp1_valid_d;
      rsp_data_q     <= rsp_data_d;
      rd_err_q       <= rd_err_d;
`ifdef LOCK_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
      lock_timeout_q <= lock_timeout_d;
`endif
    end
  end

  assign ram_rx_valid = ram_rx_valid_q;
  assign ram_din      = ram_din_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rd_err       = rd_err_q;
  assign owner        = owner_q;
  assign busy         = (state_q != IDLE);
`ifdef LOCK_TIMEOUT_EN
  assign lock_timeout = lock_timeout_q;
`else
  assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_cmd_arbiter.sv
// Bench for spi_ram_cmd_arbiter: event-schedule model checked every cycle plus directed scenario checks.
// Honours LOCK_TIMEOUT_EN the same way as the design.
module tb_spi_ram_cmd_arbiter;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [9:0] req0_din = '0, req1_din = '0;
  logic       req0_ready, req1_ready;
  logic       ram_rx_valid;
  logic [9:0] ram_din;
  logic       ram_tx_valid = 1'b0;
  logic [7:0] ram_dout = '0;
  logic       rsp0_valid, rsp1_valid, rd_err, lock_timeout, owner, busy;
  logic [7:0] rsp_data;

  spi_ram_cmd_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_din(req0_din), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_din(req1_din), .req1_ready(req1_ready),
    .ram_rx_valid(ram_rx_valid), .ram_din(ram_din),
    .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .rd_err(rd_err), .lock_timeout(lock_timeout), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // requester queues, RAM stub response disable, monitor records
  logic [9:0] q0[$], q1[$], log_q[$];
  bit         tx_off = 1'b0;
  int         acc_cyc[1024];
  int         rsp0_cnt = 0, rsp1_cnt = 0, err_cnt = 0, tmo_cnt = 0, rsp1_cyc = 0;
  logic [7:0] rsp_last = '0;

  initial forever begin
    @(posedge clk); #1;
    req0_valid = (q0.size() != 0);
    req1_valid = (q1.size() != 0);
    if (q0.size() != 0) req0_din = q0[0];
    if (q1.size() != 0) req1_din = q1[0];
  end

  initial forever begin : monitor
    logic [9:0] tmp;
    @(negedge clk);
    if (req0_valid && req0_ready) begin acc_cyc[req0_din] = cyc; tmp = q0.pop_front(); end
    if (req1_valid && req1_ready) begin acc_cyc[req1_din] = cyc; tmp = q1.pop_front(); end
    if (ram_rx_valid) log_q.push_back(ram_din);
    if (rsp0_valid) rsp0_cnt++;
    if (rsp1_valid) begin rsp1_cnt++; rsp1_cyc = cyc; rsp_last = rsp_data; end
    if (rd_err) err_cnt++;
    if (lock_timeout) tmo_cnt++;
  end

  // RAM stub: answers a read command one cycle after it sees it
  logic [7:0] s_mem[256];
  logic [7:0] s_addr = '0;
  bit         s_pend = 1'b0;
  initial begin
    for (int i = 0; i < 256; i++) s_mem[i] = '0;
    forever begin
      @(negedge clk);
      ram_tx_valid = s_pend && !tx_off && !rst;
      ram_dout     = s_mem[s_addr];
      s_pend       = 1'b0;
      if (ram_rx_valid && !rst) begin
        if (!ram_din[8])     s_addr = ram_din[7:0];
        else if (!ram_din[9]) s_mem[s_addr] = ram_din[7:0];
        else                  s_pend = 1'b1;
      end
    end
  end

  // Reference model: lock owner, read-busy window, and a schedule of expected output events.
  int         m_lock = -1, m_busy_until = 0;
  bit         m_owner = 1'b1, m_last = 1'b1;
  logic [7:0] m_mem[256];
  logic [7:0] m_addr = '0;
  bit         e_rx[1024], e_r0[1024], e_r1[1024], e_err[1024], e_tmo[1024];
  logic [9:0] e_din[1024];
  logic [7:0] e_dat[1024];
`ifdef LOCK_TIMEOUT_EN
  int         m_idle = 0;
`endif

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    for (int i = 0; i < 1024; i++) begin
      e_rx[i] = 0; e_r0[i] = 0; e_r1[i] = 0; e_err[i] = 0; e_tmo[i] = 0; e_din[i] = '0; e_dat[i] = '0;
    end
    forever begin : compare
      int  k, g;
      bit  rdb, er0, er1;
      logic [9:0] w;
      @(negedge clk);
      k = cyc % 1024;
      if (rst) begin
        m_lock = -1; m_busy_until = 0; m_owner = 1'b1; m_last = 1'b1;
        for (int i = 0; i < 1024; i++) begin
          e_rx[i] = 0; e_r0[i] = 0; e_r1[i] = 0; e_err[i] = 0; e_tmo[i] = 0;
        end
      end
      rdb = (cyc < m_busy_until);
      if (rst || rdb) begin er0 = 0; er1 = 0; end
      else if (m_lock >= 0) begin er0 = (m_lock == 0); er1 = (m_lock == 1); end
      else begin
        er0 = req0_valid && (!req1_valid || m_last);
        er1 = req1_valid && (!req0_valid || !m_last);
      end
      chk("req0_ready", 32'(req0_ready), 32'(er0));
      chk("req1_ready", 32'(req1_ready), 32'(er1));
      chk("ram_rx_valid", 32'(ram_rx_valid), 32'(e_rx[k]));
      if (e_rx[k]) chk("ram_din", 32'(ram_din), 32'(e_din[k]));
      chk("rsp0_valid", 32'(rsp0_valid), 32'(e_r0[k]));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(e_r1[k]));
      if (e_r0[k] || e_r1[k]) chk("rsp_data", 32'(rsp_data), 32'(e_dat[k]));
      chk("rd_err", 32'(rd_err), 32'(e_err[k]));
      chk("lock_timeout", 32'(lock_timeout), 32'(e_tmo[k]));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("busy", 32'(busy), 32'(!rst && (m_lock >= 0 || rdb)));
      e_rx[k] = 0; e_r0[k] = 0; e_r1[k] = 0; e_err[k] = 0; e_tmo[k] = 0;
      if (!rst) begin
        if ((req0_valid && er0) || (req1_valid && er1)) begin
          g = (req1_valid && er1) ? 1 : 0;
          w = g ? req1_din : req0_din;
          e_rx[(cyc + 1) % 1024] = 1; e_din[(cyc + 1) % 1024] = w;
          m_owner = g[0]; m_last = g[0];
          if (!w[8]) begin
            m_lock = g; m_addr = w[7:0];
`ifdef LOCK_TIMEOUT_EN
            m_idle = 0;
`endif
          end else if (!w[9]) begin
            m_mem[m_addr] = w[7:0]; m_lock = -1;
          end else begin
            m_lock = -1; m_busy_until = cyc + 3;
            if (tx_off) e_err[(cyc + 3) % 1024] = 1;
            else begin
              if (g == 1) e_r1[(cyc + 3) % 1024] = 1; else e_r0[(cyc + 3) % 1024] = 1;
              e_dat[(cyc + 3) % 1024] = m_mem[m_addr];
            end
          end
        end
`ifdef LOCK_TIMEOUT_EN
        else if (m_lock >= 0) begin
          m_idle++;
          if (m_idle == TMO) begin m_lock = -1; e_tmo[(cyc + 1) % 1024] = 1; end
        end
`endif
      end
    end
  end

  task automatic wait_quiet(input int lim);
    bit done = 0;
    for (int i = 0; i < lim && !done; i++) begin
      @(negedge clk);
      done = (q0.size() == 0 && q1.size() == 0 && !busy && !req0_valid && !req1_valid);
    end
    chk("quiet_timeout", 32'(done), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base, r0, r1, e0;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_owner", 32'(owner), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_valid", 32'(ram_rx_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // T2: both requesters contend with address+data pairs
    q0.push_back(10'h001); q0.push_back(10'h111); q0.push_back(10'h003); q0.push_back(10'h133);
    q1.push_back(10'h002); q1.push_back(10'h122);
    wait_quiet(100);
    chk("t2_w0", 32'(log_q[0]), 32'h001);
    chk("t2_w1", 32'(log_q[1]), 32'h111);
    chk("t2_w2", 32'(log_q[2]), 32'h002);
    chk("t2_w3", 32'(log_q[3]), 32'h122);
    chk("t2_w4", 32'(log_q[4]), 32'h003);
    chk("t2_w5", 32'(log_q[5]), 32'h133);

    // T1: req0 writes 0xA5 to addr 5 while req1 arrives mid-pair
    base = log_q.size();
    q0.push_back(10'h005); q0.push_back(10'h1A5);
    @(negedge clk);
    q1.push_back(10'h006);
    repeat (8) @(negedge clk);
    chk("t1_w0", 32'(log_q[base]), 32'h005);
    chk("t1_w1", 32'(log_q[base + 1]), 32'h1A5);
    chk("t1_w2", 32'(log_q[base + 2]), 32'h006);
    chk("t1_req1_after", 32'(acc_cyc[10'h006] - acc_cyc[10'h1A5]), 32'd1);

    // T3: req1 reads addr 5
    r0 = rsp0_cnt; r1 = rsp1_cnt;
    q1.push_back(10'h205); q1.push_back(10'h300);
    wait_quiet(100);
    chk("t3_rsp1_cnt", 32'(rsp1_cnt - r1), 32'd1);
    chk("t3_rsp0_cnt", 32'(rsp0_cnt - r0), 32'd0);
    chk("t3_latency", 32'(rsp1_cyc - acc_cyc[10'h300]), 32'd3);
    chk("t3_data", 32'(rsp_last), 32'hA5);

    // T4: read with the RAM not answering
    tx_off = 1'b1; e0 = err_cnt; r0 = rsp0_cnt; r1 = rsp1_cnt;
    q0.push_back(10'h300);
    wait_quiet(100);
    tx_off = 1'b0;
    chk("t4_err_cnt", 32'(err_cnt - e0), 32'd1);
    chk("t4_no_rsp", 32'((rsp0_cnt - r0) + (rsp1_cnt - r1)), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);

    // T5: req0 takes the lock and goes silent
    e0 = tmo_cnt;
    q0.push_back(10'h010);
    @(negedge clk);
    q1.push_back(10'h1FF);
    repeat (40) @(negedge clk);
`ifdef LOCK_TIMEOUT_EN
    chk("t5_tmo_cnt", 32'(tmo_cnt - e0), 32'd1);
    chk("t5_req1_done", 32'(q1.size()), 32'd0);
    chk("t5_tmo_gap", 32'(acc_cyc[10'h1FF] - acc_cyc[10'h010]), 32'd17);
`else
    chk("t5_tmo_cnt", 32'(tmo_cnt - e0), 32'd0);
    chk("t5_req1_stuck", 32'(q1.size()), 32'd1);
    chk("t5_still_locked", 32'(busy), 32'd1);
`endif
    q0.push_back(10'h1BB);
    wait_quiet(100);

    // T6: reset while req1 holds the lock
    q1.push_back(10'h207);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = busy && owner;
    end
    chk("t6_locked1", 32'(seen), 32'd1);
    chk("t6_rx_before", 32'(ram_rx_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rx_cleared", 32'(ram_rx_valid), 32'd0);
    chk("t6_busy_cleared", 32'(busy), 32'd0);
    chk("t6_owner_reset", 32'(owner), 32'd1);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    base = log_q.size();
    q0.push_back(10'h111); q1.push_back(10'h122);
    wait_quiet(100);
    chk("t6_first", 32'(log_q[base]), 32'h111);
    chk("t6_second", 32'(log_q[base + 1]), 32'h122);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
